// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : Bundles the two handshakes of the instruction fetch stage: the
//             req/ack channel toward instruction memory and the valid/ready
//             channel toward decode, plus decode's branch decision and the
//             sticky misalignment fault.
//  Modports :
//    master - the fetch stage (drives imem_req/imem_addr, ins/ins_valid/pc,
//             fault; receives imem_ack/imem_rdata, ins_ready/pc_src/imm_ext)
//    slave  - the environment: instruction memory plus decode
//  Signals  :
//    imem_req   fetch request, held until imem_ack
//    imem_addr  fetch address, stable while imem_req=1
//    imem_ack   imem_rdata valid this cycle, completes the request
//    imem_rdata instruction word returned by memory
//    ins        instruction presented to decode
//    ins_valid  ins/pc valid
//    ins_ready  decode consumes ins this cycle
//    pc         address of ins
//    pc_src     1 = branch taken for the consumed instruction
//    imm_ext    extended immediate for the consumed instruction
//    fault      misaligned next-PC detected, sticky until reset
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;
    logic [WIDTH-1:0] ins;
    logic             ins_valid;
    logic             ins_ready;
    logic [WIDTH-1:0] pc;
    logic             pc_src;
    logic [WIDTH-1:0] imm_ext;
    logic             fault;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output ins,
        output ins_valid,
        input  ins_ready,
        output pc,
        input  pc_src,
        input  imm_ext,
        output fault
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  ins,
        input  ins_valid,
        output ins_ready,
        input  pc,
        output pc_src,
        output imm_ext,
        input  fault
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. Owns the PC, fetches one word at a time
//             from instruction memory over req/ack, presents it to decode over
//             valid/ready and, when decode consumes it, selects the next PC
//             from the branch decision (pc + imm_ext or pc + 4). A misaligned
//             next PC parks the stage in a terminal FAULT state.
//  Ports    :
//    clk    - clock, all state on the rising edge
//    rst_n  - asynchronous active-low reset
//    bus    - fetch_unit_if.master (imem req/ack, decode valid/ready, fault)
//  Params   :
//    WIDTH    - data/address width
//    RESET_PC - first fetch address after reset
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    fetch_unit_if.master      bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_FETCH = 2'd1;
    localparam logic [1:0] c_S_HOLD  = 2'd2;
    localparam logic [1:0] c_S_FAULT = 2'd3;

    // addi x0,x0,0 : what decode sees before the first real fetch
    localparam logic [WIDTH-1:0] c_NOP     = WIDTH'(32'h0000_0013);
    localparam logic [WIDTH-1:0] c_PC_STEP = WIDTH'(4);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic             r_imem_req;
    logic [WIDTH-1:0] r_imem_addr;
    logic [WIDTH-1:0] r_ins;
    logic             r_ins_valid;
    logic [WIDTH-1:0] r_pc;
    logic             r_fault;

    // ------------------------------------------------------------------
    // Next-value wires
    // ------------------------------------------------------------------
    logic [1:0]       w_state_next;
    logic             w_imem_req_next;
    logic [WIDTH-1:0] w_imem_addr_next;
    logic [WIDTH-1:0] w_ins_next;
    logic             w_ins_valid_next;
    logic [WIDTH-1:0] w_pc_next;
    logic             w_fault_next;

    logic             w_ack_taken;
    logic             w_consume;
    logic [WIDTH-1:0] w_seq_pc;
    logic [WIDTH-1:0] w_branch_pc;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_misaligned;

    // ------------------------------------------------------------------
    // Handshake qualification and next-PC arithmetic.
    // ack/ready only mean something in their own state; elsewhere they are
    // ignored, which keeps stray strobes from corrupting the PC.
    // Adds wrap modulo 2^WIDTH; imm_ext is two's complement, so a plain add
    // handles backward branches.
    // ------------------------------------------------------------------
    assign w_ack_taken  = (r_state == c_S_FETCH) && bus.imem_ack;
    assign w_consume    = (r_state == c_S_HOLD)  && bus.ins_ready;
    assign w_seq_pc     = r_pc + c_PC_STEP;
    assign w_branch_pc  = r_pc + bus.imm_ext;
    assign w_next_pc    = bus.pc_src ? w_branch_pc : w_seq_pc;
    assign w_misaligned = |w_next_pc[1:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                w_state_next = c_S_FETCH;
            end
            c_S_FETCH: begin
                if (w_ack_taken) begin
                    w_state_next = c_S_HOLD;
                end
            end
            c_S_HOLD: begin
                if (w_consume) begin
                    w_state_next = w_misaligned ? c_S_FAULT : c_S_FETCH;
                end
            end
            c_S_FAULT: begin
                // Terminal: only reset leaves this state.
                w_state_next = c_S_FAULT;
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic. Produces the next values of the registered outputs
    // so every port is driven straight from a flop.
    // ------------------------------------------------------------------
    always_comb begin
        w_imem_req_next  = r_imem_req;
        w_imem_addr_next = r_imem_addr;
        w_ins_next       = r_ins;
        w_ins_valid_next = r_ins_valid;
        w_pc_next        = r_pc;
        w_fault_next     = r_fault;
        case (r_state)
            c_S_IDLE: begin
                // Launch the first fetch one edge after reset release.
                w_imem_req_next  = 1'b1;
                w_imem_addr_next = RESET_PC;
            end
            c_S_FETCH: begin
                // Request and address hold steady until memory answers.
                if (w_ack_taken) begin
                    w_ins_next       = bus.imem_rdata;
                    w_pc_next        = r_imem_addr;
                    w_ins_valid_next = 1'b1;
                    w_imem_req_next  = 1'b0;
                end
            end
            c_S_HOLD: begin
                if (w_consume) begin
                    w_ins_valid_next = 1'b0;
                    // The offending address is kept on imem_addr for debug
                    // even though no request is issued for it.
                    w_imem_addr_next = w_next_pc;
                    if (w_misaligned) begin
                        w_fault_next    = 1'b1;
                        w_imem_req_next = 1'b0;
                    end else begin
                        w_imem_req_next = 1'b1;
                    end
                end
            end
            c_S_FAULT: begin
                w_imem_req_next  = 1'b0;
                w_ins_valid_next = 1'b0;
            end
            default: begin
                w_imem_req_next  = 1'b0;
                w_ins_valid_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers. Reset abandons any outstanding memory request.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
            r_ins       <= c_NOP;
            r_ins_valid <= 1'b0;
            r_pc        <= RESET_PC;
            r_fault     <= 1'b0;
        end else begin
            r_imem_req  <= w_imem_req_next;
            r_imem_addr <= w_imem_addr_next;
            r_ins       <= w_ins_next;
            r_ins_valid <= w_ins_valid_next;
            r_pc        <= w_pc_next;
            r_fault     <= w_fault_next;
        end
    end

    // ------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------
    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_imem_addr;
    assign bus.ins       = r_ins;
    assign bus.ins_valid = r_ins_valid;
    assign bus.pc        = r_pc;
    assign bus.fault     = r_fault;

endmodule
`default_nettype wire
